// File: rtl/fifo_multi_ch_if.sv
// Handshake/status bundle for fifo_multi_ch: per-channel push/pop, packed data,
// shared thresholds and per-channel flags.
interface fifo_multi_ch_if #(
  parameter int DATA_SIZE = 6,
  parameter int ADDR_SIZE = 2,
  parameter int NUM_CH    = 4
);
  localparam int CNT_W = ADDR_SIZE + 1;

  logic [NUM_CH-1:0]           push;
  logic [NUM_CH-1:0]           pop;
  logic [NUM_CH*DATA_SIZE-1:0] data_in;
  logic [CNT_W-1:0]            af_th;
  logic [CNT_W-1:0]            ae_th;
  logic [NUM_CH-1:0]           err_clr;
  logic [NUM_CH*DATA_SIZE-1:0] data_out;
  logic [NUM_CH-1:0]           valid_out;
  logic [NUM_CH*CNT_W-1:0]     count;
  logic [NUM_CH-1:0]           empty;
  logic [NUM_CH-1:0]           full;
  logic [NUM_CH-1:0]           almost_full;
  logic [NUM_CH-1:0]           almost_empty;
  logic [NUM_CH-1:0]           pause;
  logic [NUM_CH-1:0]           error;

  modport master (
    output push, pop, data_in, af_th, ae_th, err_clr,
    input  data_out, valid_out, count, empty, full, almost_full, almost_empty,
           pause, error
  );

  modport slave (
    input  push, pop, data_in, af_th, ae_th, err_clr,
    output data_out, valid_out, count, empty, full, almost_full, almost_empty,
           pause, error
  );
endinterface

// File: rtl/fifo_multi_ch.sv
// NUM_CH independent FIFOs with occupancy flags, hysteretic pause and sticky
// error; one lane instance per channel, all sharing clock and thresholds.
module fifo_multi_ch_lane #(
  parameter int DATA_SIZE = 6,
  parameter int ADDR_SIZE = 2,
  parameter int CNT_W     = ADDR_SIZE + 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_push,
  input  logic                 i_pop,
  input  logic [DATA_SIZE-1:0] i_din,
  input  logic [CNT_W-1:0]     i_af_th,
  input  logic [CNT_W-1:0]     i_ae_th,
  input  logic                 i_err_clr,
  output logic [DATA_SIZE-1:0] o_dout,
  output logic                 o_vld,
  output logic [CNT_W-1:0]     o_count,
  output logic                 o_empty,
  output logic                 o_full,
  output logic                 o_af,
  output logic                 o_ae,
  output logic                 o_pause,
  output logic                 o_err
);
  localparam int DEPTH = 1 << ADDR_SIZE;

  logic [DATA_SIZE-1:0] r_mem [DEPTH];
  logic [ADDR_SIZE-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic [DATA_SIZE-1:0] r_dout;
  logic                 r_vld, r_pause, r_err;

  logic             w_empty, w_full, w_pop_ok, w_push_ok, w_err_ev;
  logic [CNT_W-1:0] w_next_count;
  logic             w_next_pause;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_pop_ok  = i_pop && !w_empty;
  // A full queue still takes a push when a word leaves in the same cycle.
  assign w_push_ok = i_push && (!w_full || w_pop_ok);
  assign w_err_ev  = (i_push && w_full && !w_pop_ok) || (i_pop && w_empty);

  always_comb begin
    w_next_count = r_count;
    if (w_push_ok && !w_pop_ok)
      w_next_count = r_count + CNT_W'(1);
    else if (w_pop_ok && !w_push_ok)
      w_next_count = r_count - CNT_W'(1);
  end

  // Set beats clear so a misprogrammed af_th <= ae_th fails safe (paused).
  always_comb begin
    w_next_pause = r_pause;
    if (w_next_count >= i_af_th)
      w_next_pause = 1'b1;
    else if (w_next_count <= i_ae_th)
      w_next_pause = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok)
      r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
      r_vld    <= 1'b0;
      r_pause  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_pause <= w_next_pause;
      r_vld   <= w_pop_ok;
      r_err   <= w_err_ev || (r_err && !i_err_clr);
      if (w_push_ok)
        r_wr_ptr <= r_wr_ptr + ADDR_SIZE'(1);
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + ADDR_SIZE'(1);
        r_dout   <= r_mem[r_rd_ptr];
      end
    end
  end

  assign o_dout  = r_dout;
  assign o_vld   = r_vld;
  assign o_count = r_count;
  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_af    = (r_count >= i_af_th);
  assign o_ae    = !w_empty && (r_count <= i_ae_th);
  assign o_pause = r_pause;
  assign o_err   = r_err;
endmodule

module fifo_multi_ch #(
  parameter int DATA_SIZE = 6,
  parameter int ADDR_SIZE = 2,
  parameter int NUM_CH    = 4
) (
  input logic           i_clk,
  input logic           i_reset,
  fifo_multi_ch_if.slave bus
);
  localparam int CNT_W = ADDR_SIZE + 1;

  logic [NUM_CH-1:0][DATA_SIZE-1:0] w_din, w_dout;
  logic [NUM_CH-1:0][CNT_W-1:0]     w_count;

  assign w_din        = bus.data_in;
  assign bus.data_out = w_dout;
  assign bus.count    = w_count;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    fifo_multi_ch_lane #(
      .DATA_SIZE (DATA_SIZE),
      .ADDR_SIZE (ADDR_SIZE),
      .CNT_W     (CNT_W)
    ) u_lane (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_push    (bus.push[g]),
      .i_pop     (bus.pop[g]),
      .i_din     (w_din[g]),
      .i_af_th   (bus.af_th),
      .i_ae_th   (bus.ae_th),
      .i_err_clr (bus.err_clr[g]),
      .o_dout    (w_dout[g]),
      .o_vld     (bus.valid_out[g]),
      .o_count   (w_count[g]),
      .o_empty   (bus.empty[g]),
      .o_full    (bus.full[g]),
      .o_af      (bus.almost_full[g]),
      .o_ae      (bus.almost_empty[g]),
      .o_pause   (bus.pause[g]),
      .o_err     (bus.error[g])
    );
  end
endmodule
